// File: rtl/clcd_pkg.sv
// rtl/clcd_pkg.sv - shared encodings for the PCF8574 character-LCD sequencer
package clcd_pkg;

  // Engine states
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_ISSUE = 3'd2;
  localparam logic [2:0] ST_ACK   = 3'd3;
  localparam logic [2:0] ST_HOLD  = 3'd4;

  // Bit positions of the control lines inside the PCF8574 byte
  localparam int PCF_BL = 3;
  localparam int PCF_EN = 2;
  localparam int PCF_RW = 1;
  localparam int PCF_RS = 0;

  // LCD opcodes that need the long settle time
  localparam logic [7:0] LCD_CLEAR = 8'h01;
  localparam logic [7:0] LCD_HOME  = 8'h02;

  // Queued command word: {nibble, rw, rs, data[7:0]}
  localparam int CMD_W   = 11;
  localparam int CMD_NIB = 10;
  localparam int CMD_RW  = 9;
  localparam int CMD_RS  = 8;

  // Build one expander byte: data nibble on the upper four lines, controls below
  function automatic logic [7:0] pcf_byte(input logic [3:0] nib, input logic bl,
                                          input logic en, input logic rw, input logic rs);
    logic [7:0] b;
    b         = {nib, 4'b0000};
    b[PCF_BL] = bl;
    b[PCF_EN] = en;
    b[PCF_RW] = rw;
    b[PCF_RS] = rs;
    return b;
  endfunction

endpackage

// File: rtl/clcd_cmd_fifo.sv
// rtl/clcd_cmd_fifo.sv - small show-ahead command FIFO with registered flags
module clcd_cmd_fifo
  import clcd_pkg::*;
#(
  parameter int WIDTH = CMD_W,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [AW:0]      count_nxt;
  logic             push;
  logic             pop;

  // A write into a full FIFO is dropped; pointers wrap naturally (power-of-two depth)
  assign push    = wr_en && !full;
  assign pop     = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  // Occupancy after this cycle, so the flags can be registered without lag
  always_comb begin
    count_nxt = count;
    if (push && !pop) begin
      count_nxt = count + 1'b1;
    end else if (pop && !push) begin
      count_nxt = count - 1'b1;
    end
  end

  // Storage array, no reset needed since empty gates every read
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers, occupancy and registered full/empty
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      full  <= (count_nxt == DEPTH_C);
      empty <= (count_nxt == '0);
    end
  end

endmodule

// File: rtl/clcd_pcf_sequencer.sv
// rtl/clcd_pcf_sequencer.sv - turns queued LCD bytes into PCF8574 EN-strobed I2C byte requests
module clcd_pcf_sequencer
  import clcd_pkg::*;
#(
  parameter logic [6:0] I2C_ADDR    = 7'h27,
  parameter int         FIFO_DEPTH  = 4,
  parameter int         CLK_HZ      = 100_000_000,
  parameter int         CMD_WAIT_US = 40,
  parameter int         CLR_WAIT_US = 1600,
  parameter int         ACK_TIMEOUT = 1024,
  parameter logic       BACKLIGHT   = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_valid,
  input  logic [7:0] i_data,
  input  logic       i_RS,
  input  logic       i_RW,
  input  logic       i_nibble,
  output logic       o_ready,
  output logic       o_busy,
  output logic       o_err,
  input  logic       i_busy,
  output logic       o_valid,
  output logic       o_RW,
  output logic [7:0] o_data,
  output logic [6:0] o_addr
);

  localparam int          CYC_PER_US = CLK_HZ / 1_000_000;
  localparam logic [31:0] CMD_LAST   = 32'(CMD_WAIT_US * CYC_PER_US - 1);
  localparam logic [31:0] CLR_LAST   = 32'(CLR_WAIT_US * CYC_PER_US - 1);
  localparam logic [31:0] TMO_LAST   = 32'(ACK_TIMEOUT - 1);

  logic [2:0]       state;
  logic [1:0]       phase;
  logic [1:0]       last_phase;
  logic [7:0]       cmd_data;
  logic             cmd_rs;
  logic             cmd_rw;
  logic             cmd_nib;
  logic [31:0]      wait_cnt;
  logic [31:0]      tmo_cnt;
  logic             busy_q;
  logic             busy_rise;
  logic             busy_fall;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CMD_W-1:0] fifo_rd_data;
  logic [7:0]       phase_byte;
  logic             long_wait;

  assign o_RW      = 1'b0;
  assign o_addr    = I2C_ADDR;
  assign o_ready   = !fifo_full;
  assign o_busy    = !fifo_empty || (state != ST_IDLE);
  assign busy_rise = i_busy && !busy_q;
  assign busy_fall = !i_busy && busy_q;
  assign fifo_pop  = (state == ST_IDLE) && !fifo_empty;

  clcd_cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (i_valid),
    .wr_data ({i_nibble, i_RW, i_RS, i_data}),
    .rd_en   (fifo_pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Expander byte for the current phase: high nibble first, EN strobed high then low
  always_comb begin
    phase_byte = pcf_byte(phase[1] ? cmd_data[3:0] : cmd_data[7:4], BACKLIGHT,
                          !phase[0], cmd_rw, cmd_rs);
    long_wait  = !cmd_rs && !cmd_nib && ((cmd_data == LCD_CLEAR) || (cmd_data == LCD_HOME));
  end

  // Sequencing engine: pop, emit each phase, wait for the I2C master, then settle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      phase      <= 2'd0;
      last_phase <= 2'd0;
      cmd_data   <= 8'h00;
      cmd_rs     <= 1'b0;
      cmd_rw     <= 1'b0;
      cmd_nib    <= 1'b0;
      wait_cnt   <= '0;
      tmo_cnt    <= '0;
      busy_q     <= 1'b0;
      o_valid    <= 1'b0;
      o_err      <= 1'b0;
      o_data     <= 8'h00;
    end else begin
      o_err  <= 1'b0;
      busy_q <= i_busy;
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            cmd_data <= fifo_rd_data[7:0];
            cmd_rs   <= fifo_rd_data[CMD_RS];
            cmd_rw   <= fifo_rd_data[CMD_RW];
            cmd_nib  <= fifo_rd_data[CMD_NIB];
            state    <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          phase      <= 2'd0;
          last_phase <= cmd_nib ? 2'd1 : 2'd3;
          state      <= ST_ISSUE;
        end
        ST_ISSUE: begin
          // o_data only changes when a new request is raised, so it holds while o_valid is low
          if (!o_valid) begin
            o_valid <= 1'b1;
            o_data  <= phase_byte;
            tmo_cnt <= '0;
          end else if (busy_rise) begin
            o_valid <= 1'b0;
            state   <= ST_ACK;
          end else if (tmo_cnt == TMO_LAST) begin
            // Master never picked the byte up: abandon this command, keep the queue
            o_valid <= 1'b0;
            o_err   <= 1'b1;
            tmo_cnt <= '0;
            state   <= ST_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        ST_ACK: begin
          if (busy_fall) begin
            if (phase == last_phase) begin
              wait_cnt <= long_wait ? CLR_LAST : CMD_LAST;
              state    <= ST_HOLD;
            end else begin
              phase <= phase + 1'b1;
              state <= ST_ISSUE;
            end
          end
        end
        ST_HOLD: begin
          if (wait_cnt == '0) begin
            state <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clcd_pcf_sequencer.sv
// tb/tb_clcd_pcf_sequencer.sv - directed self-checking bench for clcd_pcf_sequencer
module tb_clcd_pcf_sequencer;

  logic       clk;
  logic       reset_n;
  logic       i_valid;
  logic [7:0] i_data;
  logic       i_RS;
  logic       i_RW;
  logic       i_nibble;
  logic       o_ready;
  logic       o_busy;
  logic       o_err;
  logic       i_busy;
  logic       o_valid;
  logic       o_RW;
  logic [7:0] o_data;
  logic [6:0] o_addr;

  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  int         last_drop = 0;
  int         idle_cyc = 0;
  logic       model_en = 1'b0;
  logic [7:0] cap [$];
  logic [7:0] exp_q [$];

  // 1 MHz clock scaling: CMD hold = 40 cycles, CLR hold = 1600 cycles
  clcd_pcf_sequencer #(
    .I2C_ADDR    (7'h27),
    .FIFO_DEPTH  (4),
    .CLK_HZ      (1_000_000),
    .CMD_WAIT_US (40),
    .CLR_WAIT_US (1600),
    .ACK_TIMEOUT (1024),
    .BACKLIGHT   (1'b1)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_valid  (i_valid),
    .i_data   (i_data),
    .i_RS     (i_RS),
    .i_RW     (i_RW),
    .i_nibble (i_nibble),
    .o_ready  (o_ready),
    .o_busy   (o_busy),
    .o_err    (o_err),
    .i_busy   (i_busy),
    .o_valid  (o_valid),
    .o_RW     (o_RW),
    .o_data   (o_data),
    .o_addr   (o_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // I2C master model: one-cycle busy pulse per request, captures each byte
  always @(negedge clk) begin
    if (!model_en) begin
      i_busy = 1'b0;
    end else if (i_busy) begin
      i_busy    = 1'b0;
      last_drop = cyc;
    end else if (o_valid) begin
      i_busy = 1'b1;
      cap.push_back(o_data);
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] d, input logic rs, input logic rw, input logic nib);
    i_valid  = 1'b1;
    i_data   = d;
    i_RS     = rs;
    i_RW     = rw;
    i_nibble = nib;
    @(negedge clk);
    i_valid  = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (o_busy && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) check("idle_bound", {31'd0, o_busy}, 32'd0);
    idle_cyc = cyc;
  endtask

  task automatic set_exp(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                         input logic [7:0] d, input int n);
    exp_q.delete();
    exp_q.push_back(a);
    exp_q.push_back(b);
    if (n > 2) begin
      exp_q.push_back(c);
      exp_q.push_back(d);
    end
  endtask

  task automatic check_bytes(input string name);
    check({name, "_nbytes"}, cap.size(), exp_q.size());
    foreach (exp_q[i]) begin
      if (i < cap.size()) check($sformatf("%s_byte%0d", name, i), {24'd0, cap[i]}, {24'd0, exp_q[i]});
    end
  endtask

  task automatic run_cmd(input string name, input logic [7:0] d, input logic rs,
                         input logic nib, input int exp_hold);
    cap.delete();
    push(d, rs, 1'b0, nib);
    wait_idle();
    check_bytes(name);
    check({name, "_hold"}, idle_cyc - last_drop - 1, exp_hold);
  endtask

  initial begin
    int lat;
    int n;
    int nv;
    reset_n  = 1'b0;
    i_valid  = 1'b0;
    i_data   = 8'h00;
    i_RS     = 1'b0;
    i_RW     = 1'b0;
    i_nibble = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_o_valid", {31'd0, o_valid}, 32'd0);
    check("rst_o_data", {24'd0, o_data}, 32'd0);
    check("rst_o_err", {31'd0, o_err}, 32'd0);
    check("rst_o_busy", {31'd0, o_busy}, 32'd0);
    check("rst_o_RW", {31'd0, o_RW}, 32'd0);
    check("rst_o_addr", {25'd0, o_addr}, 32'h27);
    reset_n = 1'b1;
    @(negedge clk);
    check("rel_o_ready", {31'd0, o_ready}, 32'd1);
    model_en = 1'b1;

    // Data byte 0x41, RS=1: latency of the first request, four phases, short hold
    cap.delete();
    push(8'h41, 1'b1, 1'b0, 1'b0);
    lat = 1;
    while (!o_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check("latency", lat, 4);
    wait_idle();
    set_exp(8'h4D, 8'h49, 8'h1D, 8'h19, 4);
    check_bytes("data41");
    check("data41_hold", idle_cyc - last_drop - 1, 40);

    // Clear display: long hold; same opcode with RS=1 is plain data with short hold
    set_exp(8'h0C, 8'h08, 8'h1C, 8'h18, 4);
    run_cmd("clear", 8'h01, 1'b0, 1'b0, 1600);
    set_exp(8'h0D, 8'h09, 8'h1D, 8'h19, 4);
    run_cmd("data01", 8'h01, 1'b1, 1'b0, 40);

    // Nibble-mode init byte: only the high nibble is strobed
    set_exp(8'h3C, 8'h38, 8'h00, 8'h00, 2);
    run_cmd("nib30", 8'h30, 1'b0, 1'b1, 40);

    // Stalled master, six back-to-back pushes into depth 4: sixth is dropped
    cap.delete();
    model_en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i == 4) check("ready_before5", {31'd0, o_ready}, 32'd1);
      if (i == 5) check("ready_full", {31'd0, o_ready}, 32'd0);
      i_valid  = 1'b1;
      i_data   = 8'h41 + 8'(i);
      i_RS     = 1'b1;
      i_RW     = 1'b0;
      i_nibble = 1'b0;
      @(negedge clk);
    end
    i_valid  = 1'b0;
    model_en = 1'b1;
    wait_idle();
    exp_q.delete();
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(8'h4D);
      exp_q.push_back(8'h49);
      exp_q.push_back({4'(i + 1), 4'hD});
      exp_q.push_back({4'(i + 1), 4'h9});
    end
    check_bytes("burst");

    // Ack timeout: first command abandoned, queued nibble command follows
    cap.delete();
    model_en = 1'b0;
    push(8'h41, 1'b1, 1'b0, 1'b0);
    push(8'h30, 1'b0, 1'b0, 1'b1);
    n  = 0;
    nv = 0;
    while (!o_err && n < 3000) begin
      @(negedge clk);
      n++;
      if (o_valid) nv++;
    end
    check("tmo_seen", {31'd0, o_err}, 32'd1);
    check("tmo_valid_cycles", nv, 1024);
    check("tmo_o_valid", {31'd0, o_valid}, 32'd0);
    model_en = 1'b1;
    @(negedge clk);
    check("tmo_err_pulse", {31'd0, o_err}, 32'd0);
    wait_idle();
    set_exp(8'h3C, 8'h38, 8'h00, 8'h00, 2);
    check_bytes("after_tmo");

    // Reset while the second phase is being acknowledged
    cap.delete();
    push(8'h41, 1'b1, 1'b0, 1'b0);
    push(8'h42, 1'b1, 1'b0, 1'b0);
    n = 0;
    while (cap.size() < 2 && n < 100) begin
      @(negedge clk);
      #2;
      n++;
    end
    check("rst_reach_ph2", cap.size(), 2);
    @(negedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("mid_rst_o_valid", {31'd0, o_valid}, 32'd0);
    check("mid_rst_o_data", {24'd0, o_data}, 32'd0);
    check("mid_rst_o_busy", {31'd0, o_busy}, 32'd0);
    model_en = 1'b0;
    repeat (2) @(negedge clk);
    reset_n  = 1'b1;
    model_en = 1'b1;
    repeat (50) @(negedge clk);
    check("post_rst_o_busy", {31'd0, o_busy}, 32'd0);
    check("post_rst_o_ready", {31'd0, o_ready}, 32'd1);
    check("post_rst_nbytes", cap.size(), 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/clcd_pcf_sequencer.md
CLCD_PCF_SEQUENCER -- requirements
Module: clcd_pcf_sequencer

Interface
REQ-001 SHALL have parameters (name, default, meaning): I2C_ADDR, 7'h27, PCF8574 backpack address.
REQ-002 SHALL have FIFO_DEPTH, 4, command FIFO entries, power of two, 2..16.
REQ-003 SHALL have CLK_HZ, 100_000_000, clk frequency; CMD_WAIT_US, 40, post-command settle time; CLR_WAIT_US, 1600, settle time after clear/home.
REQ-004 SHALL have ACK_TIMEOUT, 1024, max cycles from o_valid rise to i_busy rise; BACKLIGHT, 1, value driven on the BL bit.
REQ-005 SHALL have ports (name, direction, width, meaning): clk  in  1  sole clock, all flops on rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 i_valid  in  1  upstream push strobe; i_data  in  8  LCD byte; i_RS  in  1  register select; i_RW  in  1  LCD read/write bit; i_nibble  in  1  send high nibble only (init mode).
REQ-008 o_ready  out  1  FIFO not full; o_busy  out  1  FIFO non-empty or engine not IDLE; o_err  out  1  one-cycle pulse on ack timeout.
REQ-009 i_busy  in  1  I2C master busy; o_valid  out  1  byte request; o_RW  out  1  I2C direction, always 0; o_data  out  8  PCF byte; o_addr  out  7  constant I2C_ADDR.

Function
REQ-010 PCF byte layout SHALL be {nibble[3:0], BL, EN, RW, RS}, BL=BACKLIGHT.
REQ-011 Push SHALL be accepted when i_valid && o_ready; {i_nibble, i_RW, i_RS, i_data} stored; push while full SHALL be dropped, FIFO unchanged.
REQ-012 o_ready SHALL be registered: 0 in the cycle after the push that fills the FIFO; push and pop in the same cycle SHALL leave count unchanged.
REQ-013 States SHALL be IDLE, LOAD, ISSUE, ACK, HOLD.
REQ-014 IDLE: FIFO non-empty -> pop into command register, go LOAD.
REQ-015 LOAD: set phase=0, phase count 4 (2 if nibble flag), go ISSUE.
REQ-016 Phases SHALL emit in order: hi nibble EN=1, hi EN=0, lo EN=1, lo EN=0.
REQ-017 ISSUE: drive o_data for current phase, o_valid=1 held until i_busy rising edge, then o_valid=0, go ACK.
REQ-018 ACK: on i_busy falling edge increment phase; phases remaining -> ISSUE, else load wait counter, go HOLD.
REQ-019 HOLD wait SHALL be CLR_WAIT_US*(CLK_HZ/1_000_000) cycles if RS=0 and data is 0x01 or 0x02 and not nibble mode, else CMD_WAIT_US*(CLK_HZ/1_000_000); counter expiry -> IDLE.
REQ-020 Latency: for a push at edge N into an empty FIFO with engine IDLE, o_valid SHALL be 1 after edge N+3.
REQ-021 i_busy edges SHALL be detected from a registered copy; i_busy activity in IDLE, LOAD or HOLD SHALL be ignored.
REQ-022 ISSUE without i_busy rise for ACK_TIMEOUT cycles SHALL drop o_valid, pulse o_err, abandon the command, go IDLE; FIFO contents kept.
REQ-023 o_data SHALL hold its last value whenever o_valid=0.

Reset
REQ-024 reset_n low SHALL immediately force state IDLE, FIFO empty, o_valid=0, o_err=0, o_data=0, o_RW=0, o_ready=1 on release, o_busy=0, counters 0, regardless of in-flight transfer.
REQ-025 o_addr SHALL equal I2C_ADDR at all times including reset.

Structure
REQ-026 Package clcd_pkg SHALL hold state encoding, PCF bit positions (BL=3, EN=2, RW=1, RS=0), and LCD opcodes CLEAR=8'h01, HOME=8'h02.
REQ-027 FIFO SHALL be sub-module clcd_cmd_fifo (width 11, depth FIFO_DEPTH, wrap-around pointers, registered full/empty).

Verification
REQ-028 Push 0x41 RS=1 RW=0 with single-cycle ack model -> o_data sequence 0x4D, 0x49, 0x1D, 0x19, then CMD_WAIT cycles before next command.
REQ-029 Push 0x01 RS=0 -> 0x0C, 0x08, 0x1C, 0x18, then HOLD of CLR_WAIT_US*100 cycles at default CLK_HZ.
REQ-030 Push 0x30 RS=0 nibble=1 -> only 0x3C, 0x38, then CMD_WAIT hold.
REQ-031 Stall I2C model, push 6 with depth 4 -> 1 in engine plus 4 stored, 6th dropped while o_ready=0; all 5 accepted emitted in order.
REQ-032 i_busy held 0 in ISSUE -> o_err pulse after 1024 cycles, o_valid 0, next FIFO entry starts.
REQ-033 Assert reset_n low during phase 2 ACK -> o_valid 0 same cycle, FIFO empty, o_busy 0 after release.
